// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: registered request/ready bus between the
// memory access controller (master) and the data RAM (slave).
interface mem_access_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16
);
  logic              ram_req;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_ready;

  modport master (
    output ram_req,
    output ram_we,
    output ram_addr,
    output ram_wdata,
    input  ram_rdata,
    input  ram_ready
  );

  modport slave (
    input  ram_req,
    input  ram_we,
    input  ram_addr,
    input  ram_wdata,
    output ram_rdata,
    output ram_ready
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: sequential LDR/STR controller, registered RAM handshake.
// Define MEM_TIMEOUT_EN to add a ram_ready watchdog driving mem_fault.
module mem_access_ctrl #(
  parameter int         DATA_W      = 32,
  parameter int         ADDR_W      = 16,
  parameter logic [3:0] OP_LDR      = 4'b1001,
  parameter logic [3:0] OP_STR      = 4'b1010,
  parameter int         TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [3:0]        op_code,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  mem_access_ctrl_if.master bus,
  output logic [DATA_W-1:0] data_ldr_out,
  output logic              ldr_valid,
  output logic              str_done,
  output logic              sel_ldr_bus,
  output logic              sel_add_bus,
  output logic              busy,
  output logic              mem_fault
);

  typedef enum logic {IDLE, REQ} state_t;

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              ldr_q, ldr_d;
  logic              str_q, str_d;
  logic              is_ldr, is_str, take;
  logic              unused_bits;

`ifdef MEM_TIMEOUT_EN
  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYC - 1);
  logic [15:0] cnt_q, cnt_d;
  logic        flt_q, flt_d;
  logic        expire;
  assign expire = cnt_q == LIMIT;
`endif

  assign is_ldr = op_code == OP_LDR;
  assign is_str = op_code == OP_STR;
  assign take   = issue_valid && (is_ldr || is_str);

  // upper address bits are dropped by design
  assign unused_bits = ^{src1[DATA_W-1:ADDR_W], 16'(TIMEOUT_CYC)};

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ldr_d   = 1'b0;
    str_d   = 1'b0;
`ifdef MEM_TIMEOUT_EN
    cnt_d   = cnt_q;
    flt_d   = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (take) begin
          state_d = REQ;
          addr_d  = src1[ADDR_W-1:0];
          we_d    = is_str;
          if (is_str) wdata_d = src2;
`ifdef MEM_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      REQ: begin
        if (bus.ram_ready) begin
          state_d = IDLE;
          if (we_q) begin
            str_d = 1'b1;
          end else begin
            ldr_d   = 1'b1;
            rdata_d = bus.ram_rdata;
          end
        end
`ifdef MEM_TIMEOUT_EN
        // a ready on the limit cycle still completes normally
        else if (expire) begin
          state_d = IDLE;
          flt_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ldr_q   <= 1'b0;
      str_q   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= '0;
      flt_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ldr_q   <= ldr_d;
      str_q   <= str_d;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= cnt_d;
      flt_q   <= flt_d;
`endif
    end
  end

  assign issue_ready   = state_q == IDLE;
  assign busy          = state_q == REQ;
  assign sel_add_bus   = busy;
  assign bus.ram_req   = busy;
  assign bus.ram_we    = we_q;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_wdata = wdata_q;
  assign data_ldr_out  = rdata_q;
  assign ldr_valid     = ldr_q;
  assign sel_ldr_bus   = ldr_q;
  assign str_done      = str_q;

`ifdef MEM_TIMEOUT_EN
  assign mem_fault = flt_q;
`else
  assign mem_fault = 1'b0;
`endif

endmodule
